// File: rtl/ram_1w_4rs_wr_arbiter.sv
// rtl/ram_1w_4rs_wr_arbiter.sv - round-robin write-port arbiter with hardware zero-fill for the 1W/4R scratch RAM
// Optional read-under-write hazard flags: define RAM_WR_ARB_HAZARD_EN.
module ram_1w_4rs_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic [NREQ*MASK_WIDTH-1:0] req_mask,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic                       wr_en,
  output logic [MASK_WIDTH-1:0]      wr_mask,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [31:0]                write_count,
  input  logic [3:0]                 rd_en,
  input  logic [4*ADDR_WIDTH-1:0]    rd_addr,
  output logic [3:0]                 rd_hazard
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [MASK_WIDTH-1:0] wr_mask_q, wr_mask_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [31:0]           write_count_q, write_count_d;
  logic                  clear_done_q, clear_done_d;

  logic                  found;
  logic                  accept;
  logic [PTR_W-1:0]      grant;
  logic [PTR_W:0]        scan;

  // Search upward from rr_ptr, wrapping mod NREQ, for the first valid requester.
  always_comb begin
    found = 1'b0;
    grant = '0;
    scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NREQ)) scan = scan - (PTR_W+1)'(NREQ);
      if (!found && req_valid[scan[PTR_W-1:0]]) begin
        found = 1'b1;
        grant = scan[PTR_W-1:0];
      end
    end
  end

  assign accept    = (state_q == ARB) && !clear_start && found;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    clear_cnt_d  = clear_cnt_q;
    wr_en_d      = 1'b0;
    wr_mask_d    = wr_mask_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    clear_done_d = 1'b0;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d     = CLEAR;
          clear_cnt_d = '0;
        end else if (found) begin
          wr_en_d   = 1'b1;
          wr_addr_d = req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
          wr_data_d = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
          wr_mask_d = req_mask[grant*MASK_WIDTH +: MASK_WIDTH];
          rr_ptr_d  = (grant == PTR_W'(NREQ-1)) ? '0 : grant + 1'b1;
        end
      end
      CLEAR: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = clear_cnt_q;
        wr_data_d   = '0;
        wr_mask_d   = '1;
        clear_cnt_d = clear_cnt_q + 1'b1;
        // Leaving on the last issue lets arbitration resume while that write is presented.
        if (clear_cnt_q == '1) begin
          clear_done_d = 1'b1;
          state_d      = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    write_count_d = write_count_q + 32'(wr_en_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      clear_cnt_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_mask_q     <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      write_count_q <= '0;
      clear_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      clear_cnt_q   <= clear_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_mask_q     <= wr_mask_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      write_count_q <= write_count_d;
      clear_done_q  <= clear_done_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_mask     = wr_mask_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign write_count = write_count_q;
  assign clear_done  = clear_done_q;
  assign clear_busy  = (state_q == CLEAR);

`ifdef RAM_WR_ARB_HAZARD_EN
  always_comb begin
    rd_hazard = '0;
    for (int p = 0; p < 4; p++)
      rd_hazard[p] = rd_en[p] & wr_en_q & (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_q);
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_addr};
  assign rd_hazard = '0;
`endif

endmodule

// File: tb/tb_ram_1w_4rs_wr_arbiter.sv
// tb/tb_ram_1w_4rs_wr_arbiter.sv - scoreboard bench for ram_1w_4rs_wr_arbiter
// Honours RAM_WR_ARB_HAZARD_EN when deciding expected rd_hazard.
module tb_ram_1w_4rs_wr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MW   = 4;
  localparam int WORDS = 1 << AW;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*MW-1:0] req_mask;
  logic               clear_start;
  logic               clear_busy;
  logic               clear_done;
  logic               wr_en;
  logic [MW-1:0]      wr_mask;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [31:0]        write_count;
  logic [3:0]         rd_en;
  logic [4*AW-1:0]    rd_addr;
  logic [3:0]         rd_hazard;

  ram_1w_4rs_wr_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr), .wr_data(wr_data),
    .write_count(write_count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_hazard(rd_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    bit            done;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_ptr = 0;
  int   m_clear_left = 0;
  int   m_count = 0;

  bit            fix_en = 0;
  int            fix_req = 0;
  logic [AW-1:0] fix_addr = '0;
  logic [DW-1:0] fix_data = '0;
  logic [MW-1:0] fix_mask = '0;
  logic [3:0]    fix_rd_en = '0;
  logic [AW-1:0] fix_rd_addr = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_hazard(input logic [AW-1:0] a);
    logic [3:0] h;
    h = '0;
`ifdef RAM_WR_ARB_HAZARD_EN
    for (int p = 0; p < 4; p++) h[p] = rd_en[p] && (rd_addr[p*AW +: AW] == a);
`endif
    return h;
  endfunction

  // One cycle of stimulus: drive at negedge, predict ready from the round-robin rules.
  task automatic step(input logic [NREQ-1:0] v, input logic cs);
    logic [NREQ-1:0] exp_ready;
    bit in_clear;
    int g;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'($urandom);
      req_data[i*DW +: DW] = $urandom;
      req_mask[i*MW +: MW] = MW'($urandom);
    end
    rd_en = 4'($urandom);
    for (int p = 0; p < 4; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3));
    if (fix_en) begin
      req_addr[fix_req*AW +: AW] = fix_addr;
      req_data[fix_req*DW +: DW] = fix_data;
      req_mask[fix_req*MW +: MW] = fix_mask;
      rd_en = fix_rd_en;
      for (int p = 0; p < 4; p++) rd_addr[p*AW +: AW] = fix_rd_addr;
    end
    req_valid = v;
    clear_start = cs;
    #1;
    exp_ready = '0;
    in_clear = (m_clear_left > 0);
    if (in_clear) begin
      m_clear_left--;
    end else if (cs) begin
      for (int a = 0; a < WORDS; a++) begin
        e.addr = AW'(a); e.data = '0; e.mask = '1; e.done = (a == WORDS-1);
        sb.push_back(e);
      end
      m_clear_left = WORDS;
    end else begin
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        e.addr = req_addr[g*AW +: AW]; e.data = req_data[g*DW +: DW];
        e.mask = req_mask[g*MW +: MW]; e.done = 0;
        sb.push_back(e);
        m_ptr = (g + 1) % NREQ;
      end
    end
    chk(req_ready == exp_ready, "req_ready", 64'(req_ready), 64'(exp_ready));
    chk(clear_busy == in_clear, "clear_busy", 64'(clear_busy), 64'(in_clear));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(wr_en == 0 && wr_addr == 0 && wr_data == 0 && wr_mask == 0, {tag, "_wr"},
        {wr_en, 10'(wr_addr), 4'(wr_mask), 32'(wr_data)}, 64'd0);
    chk(write_count == 0, {tag, "_write_count"}, 64'(write_count), 64'd0);
    chk(clear_busy == 0 && clear_done == 0 && req_ready == 0, {tag, "_ctrl"},
        {clear_busy, clear_done, req_ready}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; clear_start = 1'b0; rd_en = '0;
    #1;
    sb.delete();
    m_ptr = 0; m_clear_left = 0; m_count = 0;
    check_idle_outputs("reset_now");
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_held");
    reset = 1'b0;
  endtask

  // Monitor: every presented write must be the next expected one.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (wr_en) begin
        if (sb.size() == 0) begin
          chk(0, "unexpected_write", 64'(wr_addr), 64'd0);
        end else begin
          e = sb.pop_front();
          m_count++;
          chk(wr_addr == e.addr, "wr_addr", 64'(wr_addr), 64'(e.addr));
          chk(wr_data == e.data, "wr_data", 64'(wr_data), 64'(e.data));
          chk(wr_mask == e.mask, "wr_mask", 64'(wr_mask), 64'(e.mask));
          chk(clear_done == e.done, "clear_done", 64'(clear_done), 64'(e.done));
          chk(write_count == 32'(m_count), "write_count", 64'(write_count), 64'(m_count));
          chk(rd_hazard == exp_hazard(e.addr), "rd_hazard", 64'(rd_hazard), 64'(exp_hazard(e.addr)));
        end
      end else begin
        chk(clear_done == 0, "clear_done_idle", 64'(clear_done), 64'd0);
        chk(rd_hazard == 0, "rd_hazard_idle", 64'(rd_hazard), 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; req_valid = '0; clear_start = 1'b0; rd_en = '0;
    req_addr = '0; req_data = '0; req_mask = '0; rd_addr = '0;
    #1;
    check_idle_outputs("power_on");
    do_reset();

    // Single requester with fixed fields
    fix_en = 1; fix_req = 0; fix_addr = 10'h005; fix_data = 32'hDEADBEEF; fix_mask = 4'hF; fix_rd_en = '0;
    step(4'b0001, 0);
    fix_en = 0;
    step(4'b0000, 0);

    // Everyone requesting: rotating grants, no bubbles
    repeat (8) step(4'b1111, 0);
    // Move pointer to 3, then contend 2 vs 3
    step(4'b0100, 0);
    repeat (2) step(4'b1100, 0);
    step(4'b0000, 0);

    // Full clear with req1 waiting
    step(4'b0010, 1);
    repeat (WORDS + 1) step(4'b0010, 0);
    step(4'b0000, 0);

    // Clear aborted by reset, then a clean restart
    step(4'b0000, 1);
    repeat (101) step(4'($urandom), 0);
    do_reset();
    step(4'b1000, 0);
    step(4'b0000, 1);
    repeat (WORDS + 2) step(4'($urandom), 0);

    // Read-under-write collision on port 2
    fix_en = 1; fix_req = 0; fix_addr = 10'h010; fix_data = 32'h1234_5678; fix_mask = 4'h3;
    fix_rd_en = 4'b0100; fix_rd_addr = 10'h010;
    step(4'b0001, 0);
    step(4'b0000, 0);
    fix_en = 0;

    // Random traffic
    repeat (400) step(4'($urandom), 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) step(4'b0000, 0);
    chk(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
